// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and constants for the MMIO bus master
package mmio_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead head entry
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/mmio_bus_master.sv
// rtl/mmio_bus_master.sv - queued, single-outstanding initiator for the CPU data bus
module mmio_bus_master
  import mmio_pkg::*;
#(
  parameter int ADDR_W    = BUS_ADDR_W,
  parameter int DATA_W    = BUS_DATA_W,
  parameter int RD_LAT    = 0,
  parameter int CMD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  cmd_t                    cmd_in;
  cmd_t                    head;
  logic [$bits(cmd_t)-1:0] head_raw;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    cur_we_q;
  logic [ADDR_W-1:0]       bus_addr_q;
  logic [DATA_W-1:0]       bus_wdata_q;
  logic                    bus_we_q;
  logic                    rsp_valid_q;
  logic [DATA_W-1:0]       rsp_rdata_q;
  logic                    rsp_err_q;

  assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
  assign head   = cmd_t'(head_raw);

  sync_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmd_valid_i & ~fifo_full),
    .push_data_i (cmd_in),
    .pop_i       (pop),
    .pop_data_o  (head_raw),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // A new command starts when idle, or in the same edge the current response is taken.
  assign pop = !fifo_empty && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      bus_we_q <= 1'b0;
      case (state_q)
        ISSUE: begin
          if (cur_we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end else if (RD_LAT == 0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= bus_rdata_i;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q   <= CNT_W'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= bus_rdata_i;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase

      // Misaligned commands answer with an error and never reach the bus registers.
      if (pop) begin
        if (is_misaligned(head.addr[1:0])) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end else begin
          state_q     <= ISSUE;
          cur_we_q    <= head.we;
          bus_addr_q  <= head.addr;
          bus_wdata_q <= head.wdata;
          bus_we_q    <= head.we;
        end
      end
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_we_o    = bus_we_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mmio_bus_master.sv
// tb/tb_mmio_bus_master.sv - scoreboard bench for mmio_bus_master (RD_LAT 0 and 3 instances)
module tb_mmio_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst3_n;
  logic        cmd_valid0, cmd_ready0, cmd_we0, rsp_valid0, rsp_err0, bus_we0;
  logic        rsp_ready0 = 1'b0;
  logic [31:0] cmd_addr0, cmd_wdata0, rsp_rdata0, bus_addr0, bus_wdata0, bus_rdata0;
  logic        cmd_valid3, cmd_ready3, cmd_we3, rsp_valid3, rsp_ready3, rsp_err3, bus_we3;
  logic [31:0] cmd_addr3, cmd_wdata3, rsp_rdata3, bus_addr3, bus_wdata3, bus_rdata3;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Device read data is a fixed function of the word address.
  function automatic logic [31:0] dev_data(input logic [31:0] a);
    return (a == 32'hFFFF_F070) ? 32'h00A5_5A00 : ((a ^ 32'hC3C3_0F0F) + 32'd17);
  endfunction

  assign bus_rdata0 = dev_data(bus_addr0);

  logic [31:0] rd_pipe [3];
  always @(posedge clk) begin
    rd_pipe[0] <= dev_data(bus_addr3);
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus_rdata3 = rd_pipe[2];

  mmio_bus_master #(.RD_LAT(0), .CMD_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid0), .cmd_ready_o(cmd_ready0), .cmd_we_i(cmd_we0),
    .cmd_addr_i(cmd_addr0), .cmd_wdata_i(cmd_wdata0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0),
    .bus_addr_o(bus_addr0), .bus_we_o(bus_we0), .bus_wdata_o(bus_wdata0), .bus_rdata_i(bus_rdata0)
  );

  mmio_bus_master #(.RD_LAT(3), .CMD_DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3), .cmd_we_i(cmd_we3),
    .cmd_addr_i(cmd_addr3), .cmd_wdata_i(cmd_wdata3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_rdata_o(rsp_rdata3), .rsp_err_o(rsp_err3),
    .bus_addr_o(bus_addr3), .bus_we_o(bus_we3), .bus_wdata_o(bus_wdata3), .bus_rdata_i(bus_rdata3)
  );

  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       rsp_ready0 = 1'b0;
      1:       rsp_ready0 = 1'b1;
      default: rsp_ready0 = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct { logic err; logic [31:0] rdata; logic [31:0] addr; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  rsp_t        exp_q[$];
  wr_t         wr_q[$];
  rsp_t        r_cur;
  wr_t         w_cur;
  int          n_acc = 0;
  int          n_rsp = 0;
  logic [31:0] last_addr, prev_rdata;
  logic        prev_stall, prev_we, prev_err, e_new;

  // Transaction-level model of the RD_LAT=0 instance, checked every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_we    = 1'b0;
      last_addr  = 32'h0;
    end else begin
      if (bus_we0) begin
        chk("bus_we_expected", 32'(wr_q.size() != 0), 1);
        chk("bus_we_single_cycle", prev_we, 0);
        if (wr_q.size() != 0) begin
          w_cur = wr_q.pop_front();
          chk("bus_waddr", bus_addr0, w_cur.addr);
          chk("bus_wdata", bus_wdata0, w_cur.data);
        end
      end
      if (prev_stall) begin
        chk("stall_valid", rsp_valid0, 1);
        chk("stall_rdata", rsp_rdata0, prev_rdata);
        chk("stall_err", rsp_err0, prev_err);
      end
      if (n_acc - n_rsp < 4) chk("ready_not_full", cmd_ready0, 1);
      if (n_acc - n_rsp >= 5) chk("ready_full", cmd_ready0, 0);
      if (rsp_valid0 && rsp_ready0) begin
        chk("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          r_cur = exp_q.pop_front();
          chk("rsp_err", rsp_err0, r_cur.err);
          chk("rsp_rdata", rsp_rdata0, r_cur.rdata);
          if (!r_cur.err) last_addr = r_cur.addr;
          chk("bus_addr_at_rsp", bus_addr0, last_addr);
        end
        n_rsp++;
      end
      if (cmd_valid0 && cmd_ready0) begin
        e_new = (cmd_addr0[1:0] != 2'b00);
        exp_q.push_back('{err: e_new, rdata: (e_new || cmd_we0) ? 32'h0 : dev_data(cmd_addr0), addr: cmd_addr0});
        if (!e_new && cmd_we0) wr_q.push_back('{addr: cmd_addr0, data: cmd_wdata0});
        n_acc++;
      end
      prev_stall = rsp_valid0 && !rsp_ready0;
      prev_rdata = rsp_rdata0;
      prev_err   = rsp_err0;
      prev_we    = bus_we0;
    end
  end

  task automatic send0(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic got;
    int   n;
    cmd_valid0 = 1'b1; cmd_we0 = we; cmd_addr0 = a; cmd_wdata0 = d;
    got = 1'b0; n = 0;
    while (!got && n < 200) begin
      @(negedge clk); got = cmd_ready0;
      @(posedge clk); #1; n++;
    end
    cmd_valid0 = 1'b0;
    chk("send0_accepted", got, 1);
  endtask

  task automatic send3(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic got;
    int   n;
    cmd_valid3 = 1'b1; cmd_we3 = we; cmd_addr3 = a; cmd_wdata3 = d;
    got = 1'b0; n = 0;
    while (!got && n < 200) begin
      @(negedge clk); got = cmd_ready3;
      @(posedge clk); #1; n++;
    end
    cmd_valid3 = 1'b0;
    chk("send3_accepted", got, 1);
  endtask

  task automatic drain0(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); n++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we, mis, seen, bad_we, bad_addr, bad_valid;
    logic [31:0] a, d;
    int          n;

    rst_n = 1'b0; rst3_n = 1'b0;
    cmd_valid0 = 1'b0; cmd_we0 = 1'b0; cmd_addr0 = '0; cmd_wdata0 = '0;
    cmd_valid3 = 1'b0; cmd_we3 = 1'b0; cmd_addr3 = '0; cmd_wdata3 = '0;
    rsp_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready0, 1);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_rsp_err", rsp_err0, 0);
    chk("rst_rsp_rdata", rsp_rdata0, 0);
    chk("rst_bus_we", bus_we0, 0);
    chk("rst_bus_addr", bus_addr0, 0);
    chk("rst_bus_wdata", bus_wdata0, 0);
    chk("rst3_cmd_ready", cmd_ready3, 1);
    chk("rst3_rsp_valid", rsp_valid3, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst3_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    send0(1'b1, 32'hFFFF_F000, 32'h0000_00AB);
    @(negedge clk);
    chk("t1_we_before_issue", bus_we0, 0);
    @(negedge clk);
    chk("t1_issue_we", bus_we0, 1);
    chk("t1_issue_addr", bus_addr0, 32'hFFFF_F000);
    chk("t1_issue_wdata", bus_wdata0, 32'h0000_00AB);
    @(negedge clk);
    chk("t1_we_dropped", bus_we0, 0);
    chk("t1_rsp_valid", rsp_valid0, 1);
    chk("t1_rsp_err", rsp_err0, 0);
    chk("t1_rsp_rdata", rsp_rdata0, 0);
    drain0("t1_drain");

    send0(1'b0, 32'hFFFF_F070, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t2_lat0_valid_%0d", k), rsp_valid0, (k == 3) ? 1 : 0);
    end
    chk("t2_lat0_rdata", rsp_rdata0, 32'h00A5_5A00);
    drain0("t2_drain");

    send3(1'b0, 32'hFFFF_F070, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t2_lat3_valid_%0d", k), rsp_valid3, (k == 6) ? 1 : 0);
    end
    chk("t2_lat3_rdata", rsp_rdata3, 32'h00A5_5A00);
    chk("t2_lat3_err", rsp_err3, 0);
    repeat (3) @(posedge clk); #1;

    rdy_mode = 0;
    @(posedge clk); #1;
    send0(1'b1, 32'h0000_0100, 32'h11);
    send0(1'b0, 32'h0000_0104, 32'h0);
    send0(1'b1, 32'h0000_0108, 32'h33);
    send0(1'b0, 32'h0000_010C, 32'h0);
    send0(1'b1, 32'h0000_0110, 32'h55);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_ready_low_full", cmd_ready0, 0);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    @(negedge clk);
    chk("t3_ready_low_before_rsp", cmd_ready0, 0);
    @(negedge clk);
    chk("t3_ready_back", cmd_ready0, 1);
    drain0("t3_drain");

    send0(1'b0, 32'h0000_0002, 32'h0);
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = rsp_valid0; n++;
    end
    chk("t4_rsp_seen", seen, 1);
    chk("t4_err", rsp_err0, 1);
    chk("t4_rdata", rsp_rdata0, 0);
    chk("t4_bus_addr_held", bus_addr0, 32'h0000_0110);
    @(posedge clk); #1;
    send0(1'b1, 32'h0000_0013, 32'hDEAD);
    drain0("t4_drain");
    chk("t4_no_write", wr_q.size(), 0);

    rsp_ready3 = 1'b0;
    send3(1'b0, 32'h0000_1000, 32'h0);
    send3(1'b1, 32'h0000_1004, 32'h5);
    send3(1'b0, 32'h0000_1008, 32'h0);
    @(negedge clk);
    chk("t5_wait_addr", bus_addr3, 32'h0000_1000);
    chk("t5_wait_no_rsp", rsp_valid3, 0);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_rsp_valid", rsp_valid3, 0);
    chk("t5_rst_cmd_ready", cmd_ready3, 1);
    @(posedge clk); #1;
    rst3_n = 1'b1;
    rsp_ready3 = 1'b1;
    bad_we = 1'b0; bad_addr = 1'b0; bad_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      bad_we    = bad_we | bus_we3;
      bad_addr  = bad_addr | (bus_addr3 != 32'h0);
      bad_valid = bad_valid | rsp_valid3;
    end
    chk("t5_no_bus_we", bad_we, 0);
    chk("t5_no_bus_addr", bad_addr, 0);
    chk("t5_no_rsp", bad_valid, 0);

    rdy_mode = 2;
    for (int i = 0; i < 100; i++) begin
      we  = 1'($urandom_range(0, 1));
      mis = ($urandom_range(0, 5) == 0);
      a   = $urandom();
      d   = $urandom();
      if (!mis) a[1:0] = 2'b00;
      else if (a[1:0] == 2'b00) a[0] = 1'b1;
      send0(we, a, d);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain0("t6_drain");
    rdy_mode = 1;
    repeat (3) @(posedge clk); #1;
    chk("t6_writes_consumed", wr_q.size(), 0);
    chk("t6_rsp_count", n_rsp, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
